// File: rtl/alu_pkg.sv
// Shared opcodes and state encoding for the multi-cycle execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_REM = 4'b1011;

  typedef enum logic {IDLE, DIVIDE} state_t;

endpackage

// File: rtl/divisor_restauracao.sv
// Iterative unsigned restoring divider: one quotient bit per clock after load.
module divisor_restauracao #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quociente,
  output logic [WIDTH-1:0] resto,
  output logic             pronto
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo_q, rem_q, div_q;
  logic [WIDTH:0]   shifted, trial;

  // quociente/resto are the values after the iteration at the coming edge,
  // so the owner can capture the final result on the same edge pronto is high.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, div_q};
    if (trial[WIDTH]) begin
      resto     = shifted[WIDTH-1:0];
      quociente = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      resto     = trial[WIDTH-1:0];
      quociente = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  assign pronto = running && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      running <= 1'b1;
      cnt     <= '0;
    end else if (running) begin
      if (cnt == LAST) running <= 1'b0;
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      quo_q <= dividendo;
      rem_q <= '0;
      div_q <= divisor;
    end else if (running) begin
      quo_q <= quociente;
      rem_q <= resto;
    end
  end

endmodule

// File: rtl/alu_multiciclo.sv
// Clocked MIPS ALU with start/done handshake; DIV/REM run on an iterative divider.
module alu_multiciclo
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado,
  output logic             zero_flag,
  output logic             overflow,
  output logic             div_by_zero
);

  state_t state;
  logic   rem_sel;
  logic   is_div, b_zero, div_load, div_pronto;
  logic   ovf_c, dbz_c;
  logic [WIDTH-1:0] sum, dif, res_c, quo, rem, div_res;
  logic signed [WIDTH-1:0] a_s, b_s;

  assign a_s = A;
  assign b_s = B;

  always_comb begin
    sum    = A + B;
    dif    = A - B;
    b_zero = (B == '0);
    is_div = (op == OP_DIV) || (op == OP_REM);
    res_c  = '0;
    ovf_c  = 1'b0;
    dbz_c  = 1'b0;
    case (op)
      OP_AND: res_c = A & B;
      OP_OR:  res_c = A | B;
      OP_NOR: res_c = ~(A | B);
      OP_ADD: begin
        res_c = sum;
        ovf_c = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = dif;
        ovf_c = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: res_c = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      // Divide by zero resolves in one edge with a defined result.
      OP_DIV: if (b_zero) begin res_c = '1; dbz_c = 1'b1; end
      OP_REM: if (b_zero) begin res_c = A;  dbz_c = 1'b1; end
      default: ;
    endcase
  end

  assign div_load = start && !busy && is_div && !b_zero;
  assign div_res  = rem_sel ? rem : quo;

  divisor_restauracao #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .dividendo (A),
    .divisor   (B),
    .quociente (quo),
    .resto     (rem),
    .pronto    (div_pronto)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      resultado   <= '0;
      zero_flag   <= 1'b1;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      rem_sel     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_div && !b_zero) begin
              state   <= DIVIDE;
              busy    <= 1'b1;
              rem_sel <= (op == OP_REM);
            end else begin
              resultado   <= res_c;
              zero_flag   <= (res_c == '0);
              overflow    <= ovf_c;
              div_by_zero <= dbz_c;
              done        <= 1'b1;
            end
          end
        end
        DIVIDE: begin
          if (div_pronto) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            resultado   <= div_res;
            zero_flag   <= (div_res == '0);
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
